// File: rtl/jt5205_stream_pkg.sv
// Shared types for the jt5205 ADPCM nibble streamer: arbiter states,
// nibble-select encoding and the per-channel buffer/pointer record.
package jt5205_stream_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    localparam logic NIB_HI = 1'b0;
    localparam logic NIB_LO = 1'b1;

    // ptr is held at a fixed maximum width; channels use the low AW bits
    localparam int PTR_MAX_W = 32;

    typedef struct packed {
        logic [PTR_MAX_W-1:0] ptr;
        logic [7:0]           cur;
        logic [7:0]           nxt;
        logic                 cur_v;
        logic                 nxt_v;
        logic                 sel;
        logic                 fetch_done;
    } ch_state_t;

    function automatic logic [3:0] pick_nibble(input logic [7:0] b, input logic sel);
        return (sel == NIB_HI) ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/jt5205_stream_ch.sv
// One streamer channel: two-byte buffer, fetch pointer and irq edge handling.
// Loop-at-end reload exists only when JT5205_STREAM_LOOP_EN is defined.
module jt5205_stream_ch
    import jt5205_stream_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    input  logic          go,
    input  logic          loop_en,
    input  logic          irq,
    input  logic          data_ok,
    input  logic [7:0]    rom_data,
    output logic          need,
    output logic [AW-1:0] ptr,
    output logic [3:0]    din,
    output logic          busy,
    output logic          underrun
);

    ch_state_t st_q, st_d;
    logic      irq_l;
    logic      req;
    logic [3:0] din_d;
    logic      busy_d;
    logic      und_d;

    assign ptr  = st_q.ptr[AW-1:0];
    assign req  = irq & ~irq_l;
    assign need = busy & ~st_q.fetch_done & (~st_q.cur_v | ~st_q.nxt_v);

`ifndef JT5205_STREAM_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop_en;
`endif

    always_comb begin
        st_d   = st_q;
        din_d  = din;
        busy_d = busy;
        und_d  = 1'b0;
        if (go) begin
            st_d.ptr        = PTR_MAX_W'(start_addr);
            st_d.cur_v      = 1'b0;
            st_d.nxt_v      = 1'b0;
            st_d.sel        = NIB_HI;
            st_d.fetch_done = 1'b0;
            busy_d          = 1'b1;
        end else begin
            // Shift on the request first so an arriving byte fills the freed slot
            if (req && busy) begin
                if (st_q.cur_v) begin
                    din_d = pick_nibble(st_q.cur, st_q.sel);
                    if (st_q.sel == NIB_HI) begin
                        st_d.sel = NIB_LO;
                    end else begin
                        st_d.sel   = NIB_HI;
                        st_d.cur   = st_q.nxt;
                        st_d.cur_v = st_q.nxt_v;
                        st_d.nxt_v = 1'b0;
                    end
                end else if (st_q.fetch_done) begin
                    busy_d = 1'b0;
                end else begin
                    und_d = 1'b1;
                end
            end
            if (data_ok) begin
                if (!st_d.cur_v) begin
                    st_d.cur   = rom_data;
                    st_d.cur_v = 1'b1;
                end else begin
                    st_d.nxt   = rom_data;
                    st_d.nxt_v = 1'b1;
                end
                if (ptr == end_addr) begin
`ifdef JT5205_STREAM_LOOP_EN
                    if (loop_en) begin
                        st_d.ptr = PTR_MAX_W'(start_addr);
                    end else begin
                        st_d.fetch_done = 1'b1;
                    end
`else
                    st_d.fetch_done = 1'b1;
`endif
                end else begin
                    st_d.ptr = PTR_MAX_W'(ptr + AW'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= '0;
            irq_l    <= 1'b0;
            din      <= 4'd0;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            st_q     <= st_d;
            irq_l    <= irq;
            din      <= din_d;
            busy     <= busy_d;
            underrun <= und_d;
        end
    end

endmodule

// File: rtl/jt5205_stream.sv
// Multi-channel ADPCM nibble streamer: CH channel buffers sharing one ROM
// port through a round-robin arbiter. Optional macro: JT5205_STREAM_LOOP_EN.
module jt5205_stream
    import jt5205_stream_pkg::*;
#(
    parameter int CH = 2,
    parameter int AW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*AW-1:0] ch_start,
    input  logic [CH*AW-1:0] ch_end,
    input  logic [CH-1:0]   ch_go,
    input  logic [CH-1:0]   ch_loop,
    input  logic [CH-1:0]   irq,
    output logic [CH*4-1:0] din,
    output logic [CH-1:0]   busy,
    output logic [CH-1:0]   underrun,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_cs,
    input  logic [7:0]      rom_data,
    input  logic            rom_ok
);

    localparam int IW = (CH > 1) ? $clog2(CH) : 1;

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  last_q, last_d;
    logic           stale_q, stale_d;
    logic [AW-1:0]  addr_d;
    logic           cs_d;
    logic [CH-1:0]  need;
    logic [CH-1:0]  req_vec;
    logic [CH-1:0]  data_ok;
    logic [CH-1:0]  loop_vec;
    logic [CH*AW-1:0] ptr_flat;
    logic           grant_v;
    logic [IW-1:0]  pick;

`ifdef JT5205_STREAM_LOOP_EN
    assign loop_vec = ch_loop;
`else
    logic unused_loop;
    assign unused_loop = ^ch_loop;
    assign loop_vec    = '0;
`endif

    for (genvar n = 0; n < CH; n++) begin : g_ch
        jt5205_stream_ch #(.AW(AW)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .start_addr (ch_start[n*AW +: AW]),
            .end_addr   (ch_end[n*AW +: AW]),
            .go         (ch_go[n]),
            .loop_en    (loop_vec[n]),
            .irq        (irq[n]),
            .data_ok    (data_ok[n]),
            .rom_data   (rom_data),
            .need       (need[n]),
            .ptr        (ptr_flat[n*AW +: AW]),
            .din        (din[n*4 +: 4]),
            .busy       (busy[n]),
            .underrun   (underrun[n])
        );
    end

    // A channel with its own request in flight may not ask again
    always_comb begin
        req_vec = need;
        if (state_q == ARB_WAIT) begin
            req_vec[owner_q] = 1'b0;
        end
    end

    // Nearest requester after the last grant wins (scan far-to-near)
    always_comb begin
        grant_v = 1'b0;
        pick    = last_q;
        for (int i = CH; i >= 1; i--) begin
            if (req_vec[(int'(last_q) + i) % CH]) begin
                grant_v = 1'b1;
                pick    = IW'((int'(last_q) + i) % CH);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        stale_d = stale_q;
        addr_d  = rom_addr;
        cs_d    = rom_cs;
        data_ok = '0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_v) begin
                    state_d = ARB_WAIT;
                    owner_d = pick;
                    last_d  = pick;
                    // A restart on the grant clk already invalidates the sampled ptr
                    stale_d = ch_go[pick];
                    addr_d  = ptr_flat[int'(pick)*AW +: AW];
                    cs_d    = 1'b1;
                end
            end
            ARB_WAIT: begin
                stale_d = stale_q | ch_go[owner_q];
                if (rom_ok) begin
                    data_ok[owner_q] = ~(stale_q | ch_go[owner_q]);
                    state_d = ARB_IDLE;
                    stale_d = 1'b0;
                    cs_d    = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            last_q   <= IW'(CH - 1);
            stale_q  <= 1'b0;
            rom_addr <= '0;
            rom_cs   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            stale_q  <= stale_d;
            rom_addr <= addr_d;
            rom_cs   <= cs_d;
        end
    end

endmodule

// File: doc/jt5205_stream.md
Name: jt5205_stream

Overview:
- Multi-channel ADPCM nibble streamer for jt5205 decoder instances.
- Per channel, fetches bytes from a shared 8-bit sample ROM between programmed start/end addresses. It then delivers one 4-bit code per decoder sample request (irq rising edge), high nibble first.
- Sits between the CPU-side sound registers, the sample ROM and up to CH jt5205 cores. It replaces ad-hoc per-game feeders.

Parameters:
CH, 2, number of channels (1..8)
AW, 18, ROM byte address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ch_start  in  CH*AW  per-channel start address, channel n at [n*AW+:AW]
ch_end  in  CH*AW  per-channel last address (inclusive)
ch_go  in  CH  one-clk pulse: (re)start channel n
ch_loop  in  CH  loop at end instead of stopping
irq  in  CH  sample request from jt5205 n
din  out  CH*4  ADPCM code to jt5205 n
busy  out  CH  channel n playing
underrun  out  CH  one-clk pulse: request served with no data
rom_addr  out  AW  ROM byte address
rom_cs  out  1  ROM request
rom_data  in  8  ROM read data
rom_ok  in  1  data valid, consumed same clk

Behaviour:
- Reset values:
  - din=0, busy=0, underrun=0, rom_cs=0, rom_addr=0.
  - All channels IDLE; cur_v=0, nxt_v=0, sel=HI, fetch_done=0, irq_l=0.
- Per-channel state: ptr (next fetch address), cur/nxt byte registers with valid flags, sel nibble pointer, fetch_done.
- ch_go[n], from any state:
  - ptr<=start, cur_v<=0, nxt_v<=0, sel<=HI, fetch_done<=0, busy<=1.
  - din is not changed.
  - If an outstanding ROM request belongs to n, it is marked stale; its rom_ok data is discarded and must not advance ptr.
- Fetch need[n] = busy & ~fetch_done & (~cur_v | ~nxt_v) & no request already outstanding for n.
- ROM arbiter (FSM IDLE/WAIT):
  - IDLE: pick the requesting channel by round-robin starting after the last-granted channel. Drive rom_addr=ptr, rom_cs=1 on the next clk, go to WAIT.
  - WAIT: rom_addr and rom_cs stay stable until rom_ok.
  - On rom_ok: rom_cs=0 in the same registered update, back to IDLE. At most one request is outstanding.
  - Minimum 1 idle clk between requests.
- On rom_ok (not stale):
  - The byte goes to cur if ~cur_v, else to nxt.
  - If ptr==ch_end: loop → ptr<=ch_start; else fetch_done<=1.
  - Otherwise ptr<=ptr+1, wrapping modulo 2^AW.
- Request edge: req = irq & ~irq_l. irq_l is registered every clk. Action takes effect at the clk edge where req is high (1-clk latency to din).
- On req while busy:
  - cur_v & sel==HI: din<=cur[7:4], sel<=LO.
  - cur_v & sel==LO: din<=cur[3:0], sel<=HI, cur<=nxt, cur_v<=nxt_v, nxt_v<=0.
  - ~cur_v & fetch_done: busy<=0 (end), din held.
  - ~cur_v & ~fetch_done: underrun pulse, din held.
- req while ~busy: ignored, din held.
- ch_go and req in the same clk: ch_go wins, req dropped.
- rom_ok and req same clk on the same channel: both apply. Shift uses the pre-update nxt; the new byte lands in the slot freed after the shift.
- ch_end<ch_start: plays up to the 2^AW wrap, then continues to ch_end.

Optional Feature:
- Macro JT5205_STREAM_LOOP_EN.
- Defined: ch_loop honoured as above.
- Undefined: ch_loop ignored, treated as 0. Every channel stops at ch_end and no start-reload logic is built.

Decomposition:
- Package jt5205_stream_pkg holds:
  - arbiter state enum (ARB_IDLE, ARB_WAIT)
  - nibble-select constants NIB_HI/NIB_LO
  - channel-state typedef struct (ptr, cur, nxt, cur_v, nxt_v, sel, fetch_done)
- Sub-module jt5205_stream_ch, instantiated CH times, holds one channel's buffer, pointer and edge logic.
- The top holds the round-robin arbiter and ROM mux.

Test Plan:
- CH=2, ch0 start=0x100 end=0x101, ROM[0x100]=0xA3, ROM[0x101]=0x5C, rom_ok 2 clk after rom_cs, 4 irq edges → din0=A,3,5,C. The 5th edge drops busy0 with din0 still C. underrun never pulses.
- Same setup with ch_loop0=1 and the macro defined, 6 edges → A,3,5,C,A,3; busy0 stays 1. With the macro undefined, busy0 falls on the 5th edge.
- Both channels go on the same clk, rom_ok latency 20 clk, irq every 4 clk on both → grants alternate ch0,ch1. Both channels eventually emit correct nibbles; underrun pulses are counted and match the starvation timing.
- ch_go0 during WAIT for ch0 with new start=0x200 (ROM[0x200]=0x71) → stale byte discarded; first edge after reload gives din0=7.
- rst asserted mid-play with rom_cs=1 → rom_cs, busy and din go to 0 immediately (asynchronously). A later rom_ok has no effect.
- ch_go0 and an irq0 edge in the same clk → no din change; the next edge outputs the high nibble of ROM[start].
